// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder cell.
// The ripple chain in ripple_carry_adder is built from these cells.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder built from N full_adder cells.
// Sum, carry-out and signed overflow are registered once.
module ripple_carry_adder #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] S,
   output logic         Cout,
   output logic         V
);

   logic [N-1:0] sumComb;
   logic         carryTop;
   logic         carryBelowTop;

   logic [N-1:0] s_d, s_q;
   logic         cout_d, cout_q;
   logic         v_d, v_q;

   // Each stage owns its carry signals.
   // The chain therefore never loops through a single shared vector.
   for (genvar i = 0; i < N; i++) begin : gen_fa
      logic cIn;
      logic cOut;

      if (i == 0) begin : gen_first
         assign cIn = Cin;
      end else begin : gen_rest
         assign cIn = gen_fa[i-1].cOut;
      end

      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (cIn),
         .s    (sumComb[i]),
         .cout (cOut)
      );
   end

   assign carryTop      = gen_fa[N-1].cOut;
   assign carryBelowTop = gen_fa[N-2].cOut;

   // Overflow occurs when the carry into the sign bit differs from the carry out of it.
   always_comb begin
      s_d    = sumComb;
      cout_d = carryTop;
      v_d    = carryTop ^ carryBelowTop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         v_q    <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         v_q    <= v_d;
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;
   assign V    = v_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed vector bench for ripple_carry_adder (N=32).
// Also runs an exhaustive sweep of an N=4 instance against a behavioural reference.
module tb_ripple_carry_adder;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        rstN;
      logic [31:0] expS;
      logic        expCout;
      logic        expV;
   } vector_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] a32, b32, s32;
   logic        cin32, cout32, v32;

   logic        rst4_n;
   logic [3:0]  a4, b4, s4;
   logic        cin4, cout4, v4;

   int checks;
   int failures;

   ripple_carry_adder #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a32),
      .B     (b32),
      .Cin   (cin32),
      .S     (s32),
      .Cout  (cout32),
      .V     (v32)
   );

   ripple_carry_adder #(.N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst4_n),
      .A     (a4),
      .B     (b4),
      .Cin   (cin4),
      .S     (s4),
      .Cout  (cout4),
      .V     (v4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one vector and wait until just after the capturing edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic rstN);
      a32   = a;
      b32   = b;
      cin32 = cin;
      rst_n = rstN;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expS,
                              input logic expCout, input logic expV);
      checks++;
      if (s32 !== expS) begin
         failures++;
         $display("[TB] FAIL %s S: got %h expected %h", name, s32, expS);
      end
      checks++;
      if (cout32 !== expCout) begin
         failures++;
         $display("[TB] FAIL %s Cout: got %b expected %b", name, cout32, expCout);
      end
      checks++;
      if (v32 !== expV) begin
         failures++;
         $display("[TB] FAIL %s V: got %b expected %b", name, v32, expV);
      end
   endtask

   initial begin
      vector_t vecs[$];
      logic [4:0] refSum;
      logic       refV;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      rst4_n   = 1'b0;
      a32 = '0; b32 = '0; cin32 = 1'b0;
      a4  = '0; b4  = '0; cin4  = 1'b0;

      // Reset held two cycles, release, small values, mixed, boundaries, overflow.
      vecs.push_back('{32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0});
      vecs.push_back('{32'd5, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0});
      vecs.push_back('{32'd5, 32'd7, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0});
      vecs.push_back('{32'd1, 32'd1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0});
      vecs.push_back('{32'd1, 32'd1, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0});
      vecs.push_back('{32'd41242, 32'd312323, 1'b0, 1'b1, 32'd353565, 1'b0, 1'b0});
      vecs.push_back('{32'd62523, 32'd0, 1'b0, 1'b1, 32'd62523, 1'b0, 1'b0});
      vecs.push_back('{32'd3, 32'd32131, 1'b0, 1'b1, 32'd32134, 1'b0, 1'b0});
      vecs.push_back('{32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{32'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{32'd2, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0});
      vecs.push_back('{32'h7FFFFFFF, 32'd1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1});
      vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1});
      vecs.push_back('{32'd0, 32'd0, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0});
      // Back-to-back with a one-cycle reset in the middle.
      vecs.push_back('{32'd10, 32'd20, 1'b0, 1'b1, 32'd30, 1'b0, 1'b0});
      vecs.push_back('{32'd100, 32'd200, 1'b0, 1'b1, 32'd300, 1'b0, 1'b0});
      vecs.push_back('{32'd7, 32'd8, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0});
      vecs.push_back('{32'd3, 32'd4, 1'b1, 1'b1, 32'd8, 1'b0, 1'b0});
      vecs.push_back('{32'hFFFFFFFE, 32'd1, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0});
      vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});

      for (int i = 0; i < vecs.size(); i++) begin
         a32   = vecs[i].a;
         b32   = vecs[i].b;
         cin32 = vecs[i].cin;
         rst_n = vecs[i].rstN;
         #1;
         // New inputs must not reach the outputs before the edge.
         if (i > 0) checkOutput($sformatf("hold%0d", i), vecs[i-1].expS,
                                vecs[i-1].expCout, vecs[i-1].expV);
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].rstN);
         checkOutput($sformatf("vec%0d", i), vecs[i].expS, vecs[i].expCout, vecs[i].expV);
      end

      // Exhaustive N=4 sweep against a behavioural reference.
      @(posedge clk);
      #1;
      rst4_n = 1'b1;
      for (int x = 0; x < 512; x++) begin
         a4   = x[3:0];
         b4   = x[7:4];
         cin4 = x[8];
         @(posedge clk);
         #1;
         refSum = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
         refV   = (a4[3] == b4[3]) && (refSum[3] != a4[3]);
         checks++;
         if ({cout4, s4, v4} !== {refSum, refV}) begin
            failures++;
            $display("[TB] FAIL n4 a=%h b=%h cin=%b: got S=%h Cout=%b V=%b expected S=%h Cout=%b V=%b",
                     a4, b4, cin4, s4, cout4, v4, refSum[3:0], refSum[4], refV);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
